// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and width helpers for the debounce scheduler
package debounce_pkg;

  // Per-channel debounce FSM state; the encoding is fixed so state arrays stay 2 bits wide.
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    SETTLE_HIGH = 2'd1,
    STABLE_HIGH = 2'd2,
    SETTLE_LOW  = 2'd3
  } db_state_e;

  // Agreement counter must hold values up to STABLE_TICKS.
  function automatic int cnt_width(input int stable_ticks);
    return $clog2(stable_ticks + 1);
  endfunction

  // Scan pointer width; a single channel still needs one bit.
  function automatic int ptr_width(input int num_channels);
    return (num_channels > 1) ? $clog2(num_channels) : 1;
  endfunction

  // Prescaler width for a count of 0..tick_cycles-1.
  function automatic int tcount_width(input int tick_cycles);
    return (tick_cycles > 1) ? $clog2(tick_cycles) : 1;
  endfunction

endpackage

// File: rtl/debounce_tick_counter.sv
// rtl/debounce_tick_counter.sv - free-running sample-tick prescaler
module debounce_tick_counter
  import debounce_pkg::*;
#(
  parameter int TICK_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int TW = tcount_width(TICK_CYCLES);
  localparam logic [TW-1:0] TCOUNT_LAST = TW'(TICK_CYCLES - 1);

  logic [TW-1:0] tcount;

  // Count 0..TICK_CYCLES-1 and wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcount <= '0;
    end else if (tcount == TCOUNT_LAST) begin
      tcount <= '0;
    end else begin
      tcount <= tcount + 1'b1;
    end
  end

  // One-cycle tick on the last count of each period.
  assign tick = (tcount == TCOUNT_LAST);

endmodule

// File: rtl/debounce_scheduler.sv
// rtl/debounce_scheduler.sv - multi-channel switch debouncer with one shared, round-robin evaluator
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int TICK_CYCLES  = 50000,
  parameter int STABLE_TICKS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] sw_in,
  output logic [NUM_CHANNELS-1:0] sw_level,
  output logic [NUM_CHANNELS-1:0] sw_rise,
  output logic [NUM_CHANNELS-1:0] sw_fall,
  output logic                    overrun
);

  localparam int PW = ptr_width(NUM_CHANNELS);
  localparam int CW = cnt_width(STABLE_TICKS);
  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_CHANNELS - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(STABLE_TICKS);

  logic [NUM_CHANNELS-1:0] sync1;
  logic [NUM_CHANNELS-1:0] sync2;
  logic [NUM_CHANNELS-1:0] pending;
  logic [NUM_CHANNELS-1:0] others_pending;
  db_state_e               state [NUM_CHANNELS];
  logic [CW-1:0]           cnt   [NUM_CHANNELS];
  logic [PW-1:0]           ptr;
  logic                    tick;
  logic                    service;
  logic                    sample;
  db_state_e               cur_state;
  db_state_e               next_state;
  logic [CW-1:0]           cur_cnt;
  logic [CW-1:0]           cnt_inc;
  logic [CW-1:0]           next_cnt;
  logic                    rise_evt;
  logic                    fall_evt;

  debounce_tick_counter #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // Two-flop synchronizer for the raw switch inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
    end
  end

  // Round-robin scan pointer, one channel per clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (ptr == PTR_LAST) begin
      ptr <= '0;
    end else begin
      ptr <= ptr + 1'b1;
    end
  end

  assign service   = pending[ptr];
  assign sample    = sync2[ptr];
  assign cur_state = state[ptr];
  assign cur_cnt   = cnt[ptr];
  assign cnt_inc   = cur_cnt + 1'b1;

  // Shared next-state evaluator for whichever channel the pointer selects.
  always_comb begin
    next_state = cur_state;
    next_cnt   = cur_cnt;
    rise_evt   = 1'b0;
    fall_evt   = 1'b0;
    case (cur_state)
      STABLE_LOW: begin
        if (sample) begin
          next_state = SETTLE_HIGH;
          next_cnt   = CW'(1);
        end
      end
      SETTLE_HIGH: begin
        if (!sample) begin
          next_state = STABLE_LOW;
          next_cnt   = '0;
        end else if (cnt_inc == CNT_DONE) begin
          next_state = STABLE_HIGH;
          next_cnt   = '0;
          rise_evt   = 1'b1;
        end else begin
          next_cnt = cnt_inc;
        end
      end
      STABLE_HIGH: begin
        if (!sample) begin
          next_state = SETTLE_LOW;
          next_cnt   = CW'(1);
        end
      end
      SETTLE_LOW: begin
        if (sample) begin
          next_state = STABLE_HIGH;
          next_cnt   = '0;
        end else if (cnt_inc == CNT_DONE) begin
          next_state = STABLE_LOW;
          next_cnt   = '0;
          fall_evt   = 1'b1;
        end else begin
          next_cnt = cnt_inc;
        end
      end
      default: begin
        next_state = STABLE_LOW;
        next_cnt   = '0;
      end
    endcase
  end

  // Per-channel FSM storage; only the serviced entry is written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        state[i] <= STABLE_LOW;
        cnt[i]   <= '0;
      end
    end else if (service) begin
      state[ptr] <= next_state;
      cnt[ptr]   <= next_cnt;
    end
  end

  // Registered level and single-cycle edge pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_level <= '0;
      sw_rise  <= '0;
      sw_fall  <= '0;
    end else begin
      sw_rise <= '0;
      sw_fall <= '0;
      if (service && rise_evt) begin
        sw_rise[ptr]  <= 1'b1;
        sw_level[ptr] <= 1'b1;
      end
      if (service && fall_evt) begin
        sw_fall[ptr]  <= 1'b1;
        sw_level[ptr] <= 1'b0;
      end
    end
  end

  // Tick marks every channel pending; a coincident service loses to the new tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (tick) begin
          pending[i] <= 1'b1;
        end else if (service && (ptr == PW'(i))) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  // Channels still waiting on the previous tick, excluding the one serviced now.
  always_comb begin
    others_pending = pending;
    if (service) begin
      others_pending[ptr] = 1'b0;
    end
  end

  // Sticky overrun flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (tick && (|others_pending)) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_debounce_scheduler.sv
// tb/tb_debounce_scheduler.sv - scoreboard bench for debounce_scheduler
module tb_debounce_scheduler;

  typedef struct {
    int ch;
    bit rise;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw_in = '0;
  logic [3:0] sw2 = '0;
  logic [3:0] level, rise, fall;
  logic       ov;
  logic [3:0] level2, rise2, fall2;
  logic       ov2;
  logic [3:0] prev_level;

  int  cyc;
  int  total = 0;
  int  passed = 0;
  int  failed = 0;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  debounce_scheduler #(
    .NUM_CHANNELS(4),
    .TICK_CYCLES (8),
    .STABLE_TICKS(3)
  ) dut (
    .clk     (clk),
    .reset   (rst),
    .sw_in   (sw_in),
    .sw_level(level),
    .sw_rise (rise),
    .sw_fall (fall),
    .overrun (ov)
  );

  debounce_scheduler #(
    .NUM_CHANNELS(4),
    .TICK_CYCLES (3),
    .STABLE_TICKS(3)
  ) dut_ov (
    .clk     (clk),
    .reset   (rst),
    .sw_in   (sw2),
    .sw_level(level2),
    .sw_rise (rise2),
    .sw_fall (fall2),
    .overrun (ov2)
  );

  // Clock edges since reset release; the first edge after release is 1.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Edge at which sw_in is sampled for the first service of channel c after a drive at negedge n.
  // Tick edges are multiples of 8; channel c is serviced at edge 8m+1+c using sw_in from edge 8m+c-1.
  function automatic int first_sample(input int c, input int n);
    int m;
    m = 1;
    while (8 * m + c - 1 < n + 1) m++;
    return 8 * m + c - 1;
  endfunction

  task automatic push_ev(input int ch, input bit r, input int c);
    ev_t e;
    int  i;
    e = '{ch, r, c};
    i = 0;
    while (i < exp_q.size() && exp_q[i].cyc <= c) i++;
    exp_q.insert(i, e);
  endtask

  // Drive a new steady value; the pulse follows the third agreeing sample.
  task automatic drive(input int ch, input bit v);
    sw_in[ch] = v;
    push_ev(ch, v, first_sample(ch, cyc) + 18);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    check({"drain_", tag}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Pulse monitor: pop the expected event and compare channel, kind and cycle.
  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < 4; c++) begin
        if (rise[c] || fall[c]) begin : pulse_seen
          ev_t e;
          if (exp_q.size() == 0) begin
            check($sformatf("unexpected_pulse_ch%0d", c), 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("pulse_channel", c, e.ch);
            check($sformatf("pulse_kind_ch%0d", c), rise[c], e.rise);
            check($sformatf("pulse_cycle_ch%0d", c), cyc, e.cyc);
            check($sformatf("level_changes_with_pulse_ch%0d", c), level[c] ^ prev_level[c], 1);
          end
        end
      end
    end
    prev_level <= level;
  end

  initial begin
    int e_cyc;
    int x;
    int n;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_level", level, 0);
    check("reset_rise", rise, 0);
    check("reset_fall", fall, 0);
    check("reset_overrun", ov, 0);
    check("reset_overrun_fast", ov2, 0);
    rst = 1'b0;

    // clean press on channel 2
    repeat (3) @(negedge clk);
    drive(2, 1'b1);
    wait_drain("press_ch2", 80);
    check("level_after_press_ch2", level, 4'b0100);

    // bounce on channel 0, phase chosen so no three consecutive samples agree
    @(negedge clk);
    while (cyc % 8 != 1) @(negedge clk);
    e_cyc = cyc + 64;
    for (int seg = 0; seg < 8; seg++) begin
      sw_in[0] = (seg % 2 == 0);
      repeat (5) @(negedge clk);
    end
    sw_in[0] = 1'b1;
    push_ev(0, 1'b1, e_cyc);
    wait_drain("bounce_ch0", 80);
    check("level_after_bounce_ch0", level, 4'b0101);

    // press then release on channel 1
    @(negedge clk);
    drive(1, 1'b1);
    wait_drain("press_ch1", 80);
    check("level_after_press_ch1", level, 4'b0111);
    @(negedge clk);
    drive(1, 1'b0);
    wait_drain("release_ch1", 80);
    check("level_after_release_ch1", level, 4'b0101);

    // release channels 0 and 2 together, then press all four in one clock
    @(negedge clk);
    drive(0, 1'b0);
    drive(2, 1'b0);
    wait_drain("release_ch0_ch2", 80);
    check("level_all_low", level, 4'b0000);
    @(negedge clk);
    while (cyc % 8 != 3) @(negedge clk);
    for (int c = 0; c < 4; c++) drive(c, 1'b1);
    wait_drain("simultaneous", 80);
    check("level_all_high", level, 4'b1111);
    check("no_overrun_slow_tick", ov, 0);

    // overrun on the fast-tick instance is set and sticky
    check("overrun_set", ov2, 1);
    repeat (20) @(negedge clk);
    check("overrun_sticky", ov2, 1);

    // release channel 3, then reset while it settles high again
    @(negedge clk);
    drive(3, 1'b0);
    wait_drain("release_ch3", 80);
    check("level_before_reset", level, 4'b0111);
    @(negedge clk);
    sw_in[3] = 1'b1;
    x = first_sample(3, cyc);
    n = 0;
    while (cyc < x + 6 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reached_settle_window", cyc, x + 6);
    #2 rst = 1'b1;
    #1;
    check("async_reset_level", level, 0);
    check("async_reset_rise", rise, 0);
    check("async_reset_fall", fall, 0);
    check("async_reset_overrun_fast", ov2, 0);
    sw_in = 4'b1000;
    @(negedge clk);
    rst = 1'b0;
    // channel 3 must restart from STABLE_LOW and need three full samples again
    push_ev(3, 1'b1, first_sample(3, 0) + 18);
    wait_drain("restart_ch3", 80);
    check("level_after_restart", level, 4'b1000);
    check("overrun_after_restart", ov, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
